// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall-vector merge, exception/ERET flush with a
// post-flush recovery window, and a sticky stall watchdog. Optional macro: PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int          RECOVER_CYCLES = 2,
  parameter int          STALL_LIMIT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        except_valid,
  input  logic        except_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        dbg_state
);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  localparam logic [3:0]  REC_INIT = 4'(RECOVER_CYCLES);
  localparam logic [15:0] WD_LIMIT = 16'(STALL_LIMIT);

  state_t      state, state_next;
  logic [3:0]  rec_cnt, rec_next;
  logic [15:0] wd_cnt, wd_next;

  assign dbg_state = state;

  // except_valid is a single-cycle commit pulse from mem: there is no ready side,
  // the flush and redirect are taken in the same cycle it is seen high.
  always_comb begin
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = 32'h0;
    state_next = state;
    rec_next   = rec_cnt;
    if (!rst) begin
      if (except_valid) begin
        flush      = 1'b1;
        new_pc     = except_eret ? cp0_epc : EXC_VECTOR;
        state_next = RECOVER;
        rec_next   = REC_INIT;
      end else if (state == RECOVER) begin
        if (stallreq_if) stall = 6'b000011;
        if (rec_cnt == 4'd1) begin
          state_next = RUN;
          rec_next   = 4'd0;
        end else begin
          rec_next = rec_cnt - 4'd1;
        end
      end else begin
        if (stallreq_mem)     stall = 6'b011111;
        else if (stallreq_ex) stall = 6'b001111;
        else if (stallreq_id) stall = 6'b000111;
        else if (stallreq_if) stall = 6'b000011;
      end
    end
  end

  // Watchdog count saturates at the limit; flush always forces stall[0]=0.
  always_comb begin
    wd_next = wd_cnt;
    if (flush || !stall[0])      wd_next = 16'd0;
    else if (wd_cnt != WD_LIMIT) wd_next = wd_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      rec_cnt       <= 4'd0;
      wd_cnt        <= 16'd0;
      stall_timeout <= 1'b0;
    end else begin
      state   <= state_next;
      rec_cnt <= rec_next;
      wd_cnt  <= wd_next;
      if (wd_next == WD_LIMIT) stall_timeout <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      if (stall[0]) perf_stall_cnt <= perf_stall_cnt + 32'h1;
      if (flush)    perf_flush_cnt <= perf_flush_cnt + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for per-cycle behaviour plus
// hand sequences for reset-in-stall and (with PIPE_CTRL_PERF_EN) the perf counters.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        except_valid, except_eret;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic        dbg_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .RECOVER_CYCLES(2), .STALL_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .except_valid(except_valid), .except_eret(except_eret), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .stall_timeout(stall_timeout),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic        rst, rq_if, rq_id, rq_ex, rq_mem, ev, eret;
    logic [31:0] epc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_to;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic i, input logic d, input logic e,
                       input logic m, input logic v, input logic er, input logic [31:0] pc);
    rst = r; stallreq_if = i; stallreq_id = d; stallreq_ex = e; stallreq_mem = m;
    except_valid = v; except_eret = er; cp0_epc = pc;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
    //                rst if id ex mem ev er epc           stall     fl pc            to
    vecs.push_back(vec_t'{1, 0, 0, 0, 1, 1, 0, 32'h0,     6'b000000, 0, 32'h0,     0}); // 0 reset holds outputs low
    vecs.push_back(vec_t'{1, 0, 0, 0, 0, 0, 0, 32'h0,     6'b000000, 0, 32'h0,     0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 32'h0,     6'b000000, 0, 32'h0,     0}); // 2 idle
    vecs.push_back(vec_t'{0, 0, 1, 1, 0, 0, 0, 32'h0,     6'b001111, 0, 32'h0,     0}); // 3 ex over id
    vecs.push_back(vec_t'{0, 0, 1, 0, 0, 0, 0, 32'h0,     6'b000111, 0, 32'h0,     0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 32'h0,     6'b000000, 0, 32'h0,     0});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 32'h0,     6'b000011, 0, 32'h0,     0}); // 6 if only
    vecs.push_back(vec_t'{0, 0, 1, 0, 1, 0, 0, 32'h0,     6'b011111, 0, 32'h0,     0}); // 7 mem wins
    vecs.push_back(vec_t'{0, 0, 0, 0, 1, 1, 0, 32'h0,     6'b000000, 1, 32'h20,    0}); // 8 exception
    vecs.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 32'h0,     6'b000000, 0, 32'h0,     0}); // 9 masked
    vecs.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 32'h0,     6'b000000, 0, 32'h0,     0}); // 10 masked
    vecs.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 32'h0,     6'b001111, 0, 32'h0,     0}); // 11 honoured
    vecs.push_back(vec_t'{0, 0, 0, 1, 0, 1, 1, 32'h1234,  6'b000000, 1, 32'h1234,  0}); // 12 ERET
    vecs.push_back(vec_t'{0, 0, 1, 0, 0, 1, 0, 32'h1234,  6'b000000, 1, 32'h20,    0}); // 13 exc in RECOVER
    vecs.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 32'h0,     6'b000000, 0, 32'h0,     0}); // 14 masked again
    vecs.push_back(vec_t'{0, 1, 0, 1, 0, 0, 0, 32'h0,     6'b000011, 0, 32'h0,     0}); // 15 if honoured
    vecs.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 32'h0,     6'b001111, 0, 32'h0,     0}); // 16 back in RUN
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 1, 32'h1234,  6'b000000, 0, 32'h0,     0}); // 17 lone eret ignored
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 32'h0,     6'b000011, 0, 32'h0,     0}); // 18 3-cycle stall
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 32'h0,     6'b000011, 0, 32'h0,     0});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 32'h0,     6'b000011, 0, 32'h0,     0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 32'h0,     6'b000000, 0, 32'h0,     0}); // 21 no trip
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 32'h0,     6'b000011, 0, 32'h0,     0}); // 22 4-cycle stall
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 32'h0,     6'b000011, 0, 32'h0,     0});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 32'h0,     6'b000011, 0, 32'h0,     0});
    vecs.push_back(vec_t'{0, 1, 0, 0, 0, 0, 0, 32'h0,     6'b000011, 0, 32'h0,     0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 32'h0,     6'b000000, 0, 32'h0,     1}); // 26 tripped
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, 0, 32'h0,     6'b000000, 0, 32'h0,     1}); // 27 sticky
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 1, 0, 32'h0,     6'b000000, 1, 32'h20,    1}); // 28 enter RECOVER
    vecs.push_back(vec_t'{1, 0, 0, 1, 0, 0, 0, 32'h0,     6'b000000, 0, 32'h0,     1}); // 29 rst mid-RECOVER
    vecs.push_back(vec_t'{0, 0, 0, 1, 0, 0, 0, 32'h0,     6'b001111, 0, 32'h0,     0}); // 30 state cleared

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].rq_if, vecs[k].rq_id, vecs[k].rq_ex, vecs[k].rq_mem,
            vecs[k].ev, vecs[k].eret, vecs[k].epc);
      #1;
      check("stall", k, 32'(stall), 32'(vecs[k].e_stall));
      check("flush", k, 32'(flush), 32'(vecs[k].e_flush));
      check("new_pc", k, new_pc, vecs[k].e_pc);
      check("stall_timeout", k, 32'(stall_timeout), 32'(vecs[k].e_to));
    end

    // Reset in the middle of a long stall must restart the watchdog count.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
    end
    @(negedge clk); drive(1, 1, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
    end
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 32'h0); #1;
    check("wd_reset_mid_stall", 0, 32'(stall_timeout), 32'h0);

`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 32'h0); #1;
    check("perf_stall_rst", 0, perf_stall_cnt, 32'd0);
    check("perf_flush_rst", 0, perf_flush_cnt, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
    end
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 0, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 1, 32'h40);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 32'h0); #1;
    check("perf_stall_cnt", 1, perf_stall_cnt, 32'd5);
    check("perf_flush_cnt", 1, perf_flush_cnt, 32'd2);
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 32'h0); #1;
    check("perf_stall_clr", 2, perf_stall_cnt, 32'd0);
    check("perf_flush_clr", 2, perf_flush_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
